// File: rtl/collision_pkg.sv
// collision_pkg: shared state encoding and counter widths for the multi-lane collision game.
package collision_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        GRACE = 2'd2,
        OVER  = 2'd3
    } state_t;
    localparam int GRACE_W = 4;
    localparam int LIVES_W = 3;
endpackage

// File: rtl/collision_lane.sv
// collision_lane: combinational hit / cleared flags for one pipe lane against the bird column.
module collision_lane #(
    parameter int ROWS = 16
) (
    input  logic [ROWS-1:0] bird,
    input  logic [ROWS-1:0] lane,
    input  logic            valid,
    output logic            hit,
    output logic            cleared
);
    logic [ROWS-1:0] overlap;
    assign overlap = bird & lane;
    assign hit     = valid & |overlap;
    // an empty lane is present but scores nothing
    assign cleared = valid & |lane & ~|overlap;
endmodule

// File: rtl/collision_multi.sv
// collision_multi: game FSM with lives, grace period, saturating score and high score over several pipe lanes.
module collision_multi
    import collision_pkg::*;
#(
    parameter int ROWS        = 16,
    parameter int LANES       = 2,
    parameter int SCORE_W     = 10,
    parameter int LIVES       = 3,
    parameter int GRACE_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clkP,
    input  logic [ROWS-1:0]       bird,
    input  logic [LANES*ROWS-1:0] pipe,
    input  logic [LANES-1:0]      pipe_valid,
    output logic [SCORE_W-1:0]    score,
    output logic [SCORE_W-1:0]    high_score,
    output logic [2:0]            lives_left,
    output logic [1:0]            state,
    output logic                  gameover,
    output logic                  hit_pulse
);
    logic [LANES-1:0]   lane_hit, lane_clr;
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d, high_q, high_d, score_inc;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [GRACE_W-1:0] grace_q, grace_d;
    logic               hit_q, hit_d, hit_now;
    logic [SCORE_W:0]   clr_sum, score_sum;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            collision_lane #(.ROWS(ROWS)) u_lane (
                .bird   (bird),
                .lane   (pipe[k*ROWS +: ROWS]),
                .valid  (pipe_valid[k]),
                .hit    (lane_hit[k]),
                .cleared(lane_clr[k])
            );
        end
    endgenerate

    // floor contact counts every clk; lane contact only on a pipe-advance strobe
    always_comb begin
        clr_sum = '0;
        for (int i = 0; i < LANES; i++) clr_sum = clr_sum + {{SCORE_W{1'b0}}, lane_clr[i]};
        score_sum = {1'b0, score_q} + clr_sum;
        score_inc = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        hit_now   = ~|bird | bird[0] | (clkP & |lane_hit);
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        lives_d = lives_q;
        grace_d = grace_q;
        hit_d   = 1'b0;
        case (state_q)
            IDLE, OVER: if (start) begin
                state_d = PLAY;
                score_d = '0;
                lives_d = LIVES_W'(LIVES);
                grace_d = '0;
            end
            PLAY: if (hit_now) begin
                hit_d   = 1'b1;
                lives_d = lives_q - LIVES_W'(1);
                if (lives_q == LIVES_W'(1)) begin
                    state_d = OVER;
                    high_d  = score_q > high_q ? score_q : high_q;
                end else begin
                    state_d = GRACE;
                    grace_d = GRACE_W'(GRACE_TICKS);
                end
            end else if (clkP) score_d = score_inc;
            GRACE: if (clkP) begin
                score_d = score_inc;
                grace_d = grace_q - GRACE_W'(1);
                if (grace_q == GRACE_W'(1)) state_d = PLAY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            score_q <= '0;
            high_q  <= '0;
            lives_q <= LIVES_W'(LIVES);
            grace_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            high_q  <= high_d;
            lives_q <= lives_d;
            grace_q <= grace_d;
            hit_q   <= hit_d;
        end
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign lives_left = lives_q;
    assign state      = state_q;
    assign gameover   = state_q == OVER;
    assign hit_pulse  = hit_q;
endmodule

// File: tb/tb_collision_multi.sv
// tb_collision_multi: scoreboard bench driving a default instance and a SCORE_W=4 instance in lockstep.
module tb_collision_multi;
    localparam logic [15:0] B_OK  = 16'h0100;
    localparam logic [31:0] CLEAN = 32'hF000_000F;

    logic        clk = 1'b0;
    logic        reset, start, clkP;
    logic [15:0] bird;
    logic [31:0] pipe;
    logic [1:0]  pipe_valid;
    logic [9:0]  score, high_score;
    logic [2:0]  lives_left, lives_s;
    logic [1:0]  state, state_s;
    logic        gameover, hit_pulse, go_s, hit_s;
    logic [3:0]  score_s, high_s;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] lives;
        logic [9:0] score;
        logic [9:0] high;
        logic       hit;
        logic       go;
        logic [1:0] st_s;
        logic [2:0] lives_s;
        logic [3:0] score_s;
        logic [3:0] high_s;
        logic       hit_s;
        logic       go_s;
    } snap_t;

    snap_t exp_q[$], act_q[$];
    int n_checks = 0, n_fail = 0;
    int m_st[2], m_score[2], m_high[2], m_lives[2], m_grace[2];
    bit m_hit[2];
    int m_max[2] = '{1023, 15};

    collision_multi dut (
        .clk(clk), .reset(reset), .start(start), .clkP(clkP), .bird(bird), .pipe(pipe),
        .pipe_valid(pipe_valid), .score(score), .high_score(high_score), .lives_left(lives_left),
        .state(state), .gameover(gameover), .hit_pulse(hit_pulse)
    );

    collision_multi #(.SCORE_W(4)) dut_s (
        .clk(clk), .reset(reset), .start(start), .clkP(clkP), .bird(bird), .pipe(pipe),
        .pipe_valid(pipe_valid), .score(score_s), .high_score(high_s), .lives_left(lives_s),
        .state(state_s), .gameover(go_s), .hit_pulse(hit_s)
    );

    always #5 clk = ~clk;

    // reference model advances on the driven inputs, then the DUT outputs are captured after the edge
    task automatic tick();
        int clr;
        bit floor_hit, lane_hit;
        logic [15:0] lane;
        snap_t e, a;
        floor_hit = (bird == 16'h0) || bird[0];
        lane_hit = 0;
        clr = 0;
        for (int k = 0; k < 2; k++) begin
            lane = pipe[k*16 +: 16];
            if (pipe_valid[k]) begin
                if ((bird & lane) != 16'h0) lane_hit = 1;
                else if (lane != 16'h0) clr++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            m_hit[i] = 0;
            if (reset) begin
                m_st[i] = 0; m_score[i] = 0; m_high[i] = 0; m_lives[i] = 3; m_grace[i] = 0;
            end else if (m_st[i] == 0 || m_st[i] == 3) begin
                if (start) begin
                    m_st[i] = 1; m_score[i] = 0; m_lives[i] = 3; m_grace[i] = 0;
                end
            end else if (m_st[i] == 1) begin
                if (floor_hit || (clkP && lane_hit)) begin
                    m_hit[i] = 1;
                    m_lives[i]--;
                    if (m_lives[i] == 0) begin
                        m_st[i] = 3;
                        if (m_score[i] > m_high[i]) m_high[i] = m_score[i];
                    end else begin
                        m_st[i] = 2;
                        m_grace[i] = 4;
                    end
                end else if (clkP) begin
                    m_score[i] = (m_score[i] + clr > m_max[i]) ? m_max[i] : m_score[i] + clr;
                end
            end else if (clkP) begin
                m_score[i] = (m_score[i] + clr > m_max[i]) ? m_max[i] : m_score[i] + clr;
                m_grace[i]--;
                if (m_grace[i] == 0) m_st[i] = 1;
            end
        end
        e.st = 2'(m_st[0]);      e.lives = 3'(m_lives[0]);   e.score = 10'(m_score[0]);
        e.high = 10'(m_high[0]); e.hit = m_hit[0];           e.go = (m_st[0] == 3);
        e.st_s = 2'(m_st[1]);    e.lives_s = 3'(m_lives[1]); e.score_s = 4'(m_score[1]);
        e.high_s = 4'(m_high[1]); e.hit_s = m_hit[1];        e.go_s = (m_st[1] == 3);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a.st = state;     a.lives = lives_left;   a.score = score;     a.high = high_score;
        a.hit = hit_pulse; a.go = gameover;       a.st_s = state_s;    a.lives_s = lives_s;
        a.score_s = score_s; a.high_s = high_s;   a.hit_s = hit_s;     a.go_s = go_s;
        act_q.push_back(a);
    endtask

    task automatic drive(input logic s, input logic cp, input logic [15:0] b,
                         input logic [31:0] p, input logic [1:0] v);
        start = s; clkP = cp; bird = b; pipe = p; pipe_valid = v;
        tick();
    endtask

    task automatic test_reset();
        snap_t e, a;
        reset = 1'b1;
        drive(1, 1, 16'h0, CLEAN, 2'b11);
        drive(1, 1, 16'h0, CLEAN, 2'b11);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (score !== 10'd0 || high_score !== 10'd0) begin n_fail++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score, high_score); end
        n_checks++; if (lives_left !== 3'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", lives_left); end
        n_checks++; if (gameover !== 1'b0 || hit_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got go=%b hit=%b want 0/0", gameover, hit_pulse); end
        reset = 1'b0;
        drive(0, 1, 16'h0, CLEAN, 2'b11);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", state); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL reset_sb: got %h want %h", a, e); end
        end
    endtask

    task automatic test_scoring();
        snap_t e, a;
        drive(1, 0, B_OK, CLEAN, 2'b11);
        for (int i = 0; i < 3; i++) drive(0, 1, B_OK, CLEAN, 2'b11);
        n_checks++; if (score !== 10'd6) begin n_fail++; $display("FAIL score_six: got %0d want 6", score); end
        n_checks++; if (lives_left !== 3'd3 || state !== 2'd1) begin n_fail++; $display("FAIL play_state: got lives=%0d st=%0d want 3/1", lives_left, state); end
        drive(0, 0, B_OK, CLEAN, 2'b11);
        drive(0, 1, B_OK, 32'h0000_000F, 2'b11);
        drive(0, 1, B_OK, CLEAN, 2'b01);
        drive(1, 1, B_OK, CLEAN, 2'b11);
        n_checks++; if (score !== 10'd10) begin n_fail++; $display("FAIL score_ten: got %0d want 10", score); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL scoring_sb: got %h want %h", a, e); end
        end
    endtask

    task automatic test_lane_hit();
        snap_t e, a;
        drive(0, 1, 16'h0010, 32'hF000_0010, 2'b11);
        n_checks++; if (hit_pulse !== 1'b1) begin n_fail++; $display("FAIL hit_pulse_on: got %b want 1", hit_pulse); end
        n_checks++; if (lives_left !== 3'd2 || state !== 2'd2 || score !== 10'd10) begin
            n_fail++; $display("FAIL lane_hit: got lives=%0d st=%0d score=%0d want 2/2/10", lives_left, state, score);
        end
        drive(0, 0, B_OK, 32'h0, 2'b00);
        n_checks++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_off: got %b want 0", hit_pulse); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL lane_hit_sb: got %h want %h", a, e); end
        end
    endtask

    task automatic test_grace();
        snap_t e, a;
        drive(0, 0, 16'h0, 32'h0, 2'b00);
        drive(0, 1, 16'h0010, 32'hF000_0010, 2'b11);
        for (int i = 0; i < 4; i++) drive(0, 1, B_OK, CLEAN, 2'b11);
        n_checks++; if (state !== 2'd1 || lives_left !== 3'd2 || score !== 10'd19) begin
            n_fail++; $display("FAIL grace_exit: got st=%0d lives=%0d score=%0d want 1/2/19", state, lives_left, score);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL grace_sb: got %h want %h", a, e); end
        end
    endtask

    task automatic test_gameover();
        snap_t e, a;
        drive(0, 0, 16'h0001, 32'h0, 2'b00);
        for (int i = 0; i < 4; i++) drive(0, 1, B_OK, 32'h0, 2'b00);
        drive(0, 0, 16'h0001, 32'h0, 2'b00);
        n_checks++; if (state !== 2'd3 || gameover !== 1'b1 || high_score !== 10'd19) begin
            n_fail++; $display("FAIL game_over: got st=%0d go=%b high=%0d want 3/1/19", state, gameover, high_score);
        end
        drive(0, 1, B_OK, CLEAN, 2'b11);
        drive(1, 0, B_OK, 32'h0, 2'b00);
        n_checks++; if (score !== 10'd0 || lives_left !== 3'd3 || high_score !== 10'd19) begin
            n_fail++; $display("FAIL restart: got score=%0d lives=%0d high=%0d want 0/3/19", score, lives_left, high_score);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL gameover_sb: got %h want %h", a, e); end
        end
    endtask

    task automatic test_saturate();
        snap_t e, a;
        for (int i = 0; i < 7; i++) drive(0, 1, B_OK, CLEAN, 2'b11);
        n_checks++; if (score_s !== 4'd14) begin n_fail++; $display("FAIL sat_pre: got %0d want 14", score_s); end
        drive(0, 1, B_OK, CLEAN, 2'b11);
        n_checks++; if (score_s !== 4'd15 || score !== 10'd16) begin
            n_fail++; $display("FAIL sat_clip: got small=%0d big=%0d want 15/16", score_s, score);
        end
        drive(0, 1, 16'h0001, 32'h0000_0001, 2'b01);
        n_checks++; if (lives_left !== 3'd2 || lives_s !== 3'd2) begin
            n_fail++; $display("FAIL double_hit: got %0d/%0d want 2/2", lives_left, lives_s);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL saturate_sb: got %h want %h", a, e); end
        end
    endtask

    task automatic test_reset_mid();
        snap_t e, a;
        reset = 1'b1;
        drive(0, 0, B_OK, 32'h0, 2'b00);
        reset = 1'b0;
        drive(1, 0, B_OK, 32'h0, 2'b00);
        for (int i = 0; i < 4; i++) drive(0, 1, B_OK, CLEAN, 2'b11);
        drive(0, 1, B_OK, 32'h0000_000F, 2'b11);
        for (int j = 0; j < 3; j++) begin
            drive(0, 0, 16'h0001, 32'h0, 2'b00);
            if (j < 2) for (int i = 0; i < 4; i++) drive(0, 1, B_OK, 32'h0, 2'b00);
        end
        n_checks++; if (high_score !== 10'd9 || high_s !== 4'd9) begin
            n_fail++; $display("FAIL high_nine: got %0d/%0d want 9/9", high_score, high_s);
        end
        drive(1, 0, B_OK, 32'h0, 2'b00);
        drive(0, 0, 16'h0001, 32'h0, 2'b00);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pre_reset_grace: got %0d want 2", state); end
        reset = 1'b1;
        drive(1, 1, B_OK, CLEAN, 2'b11);
        n_checks++; if (state !== 2'd0 || high_score !== 10'd0 || lives_left !== 3'd3 || gameover !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got st=%0d high=%0d lives=%0d go=%b want 0/0/3/0", state, high_score, lives_left, gameover);
        end
        reset = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL reset_mid_sb: got %h want %h", a, e); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clkP = 1'b0; bird = B_OK; pipe = 32'h0; pipe_valid = 2'b00;
        test_reset();
        test_scoring();
        test_lane_hit();
        test_grace();
        test_gameover();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
